// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block-copy engine for the 14-bit-address / 10-bit-data
// unified memory (RAM below 0x2000, ROM above). Copies a run of words in
// ascending address order from RAM or ROM into RAM, two cycles per word:
// an ISSUE cycle presents the read, the following XFER cycle writes the
// returned data straight through to the write port.
module mem_copy_engine #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2
    } state_t;

    // Last valid RAM address and last valid memory address, one bit wider
    // than an address so the end-of-range sums cannot wrap.
    localparam logic [ADDR_W:0] RAM_LAST = {2'b00, {(ADDR_W-1){1'b1}}};
    localparam logic [ADDR_W:0] MEM_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE_W    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_reg;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [ADDR_W-1:0] count_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;

    logic [ADDR_W:0]   src_end;
    logic [ADDR_W:0]   dst_end;
    logic              len_zero;
    logic              cmd_err;

    // Command validation: last source/destination address of the run,
    // computed one bit wide so an overrun is visible instead of wrapping.
    assign src_end  = {1'b0, src} + {1'b0, len} - ONE_W;
    assign dst_end  = {1'b0, dst} + {1'b0, len} - ONE_W;
    assign len_zero = (len == '0);
    assign cmd_err  = dst[ADDR_W-1] || (dst_end > RAM_LAST) || (src_end > MEM_LAST);

    // Copy sequencer: command acceptance, ISSUE/XFER alternation, abort and
    // completion status, with all control outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            count_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (len_zero) begin
                            done_reg <= 1'b1;
                            err_reg  <= 1'b0;
                        end else if (cmd_err) begin
                            // Rejected commands never touch memory.
                            done_reg <= 1'b1;
                            err_reg  <= 1'b1;
                        end else begin
                            src_reg      <= src;
                            dst_reg      <= dst;
                            count_reg    <= len;
                            err_reg      <= 1'b0;
                            busy_reg     <= 1'b1;
                            mem_read_reg <= 1'b1;
                            state_reg    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_read_reg <= 1'b0;
                    if (abort) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        err_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        mem_write_reg <= 1'b1;
                        state_reg     <= XFER;
                    end
                end
                XFER: begin
                    // The write presented this cycle lands at this edge, even
                    // when abort is also sampled here.
                    mem_write_reg <= 1'b0;
                    src_reg       <= src_reg + ONE;
                    dst_reg       <= dst_reg + ONE;
                    count_reg     <= count_reg - ONE;
                    if (abort || (count_reg == ONE)) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        err_reg   <= abort;
                        state_reg <= IDLE;
                    end else begin
                        mem_read_reg <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end
                default: begin
                    busy_reg      <= 1'b0;
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign mem_read  = mem_read_reg;
    // The read address stays on src_reg through XFER so ROM data, which is
    // combinational, remains valid while it is being written.
    assign mem_raddr = src_reg;
    assign mem_write = mem_write_reg;
    assign mem_waddr = dst_reg;
    assign mem_wdata = mem_rdata;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine: memory model (registered-read RAM,
// combinational ROM), scoreboard queues filled by the stimulus from a
// word-level copy model, and an independent monitor that checks writes
// and completions as the DUT presents them.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] src = '0;
    logic [13:0] dst = '0;
    logic [13:0] len = '0;
    logic        abort = 1'b0;
    logic        busy, done, err;
    logic        mem_read, mem_write;
    logic [13:0] mem_raddr, mem_waddr;
    logic [9:0]  mem_rdata, mem_wdata;

    mem_copy_engine #(.ADDR_W(14), .DATA_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst),
        .len(len), .abort(abort), .busy(busy), .done(done), .err(err),
        .mem_read(mem_read), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_write(mem_write), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic err_model = 1'b0;

    typedef struct {
        int          cyc;
        logic [13:0] waddr;
        logic [13:0] raddr;
        logic [9:0]  wdata;
    } wr_t;
    typedef struct {
        int   cyc;
        logic err;
    } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    logic [9:0] ram [0:8191];
    logic [9:0] ref_mem [0:8191];
    logic [9:0] ram_q;

    function automatic logic [9:0] rom_f(input int a);
        int v;
        v = a * 13 + (a >> 4) + 421;
        return v[9:0];
    endfunction

    function automatic logic [9:0] ram_init(input int a);
        int v;
        case (a)
            'h100:   v = 'h001;
            'h101:   v = 'h3FF;
            'h102:   v = 'h155;
            'h103:   v = 'h2AA;
            default: v = a * 37 + (a >> 5);
        endcase
        return v[9:0];
    endfunction

    // Memory model: RAM image loaded on the first edge, registered read,
    // write at the edge; ROM reads are combinational.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 8192; i++) ram[i] <= ram_init(i);
        end else begin
            if (mem_read) ram_q <= ram[mem_raddr[12:0]];
            if (mem_write && !mem_waddr[13]) ram[mem_waddr[12:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_raddr[13] ? rom_f(int'(mem_raddr)) : ram_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: independent of the stimulus, pops expectations as the DUT
    // presents writes and completions.
    int mon_c;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_c = cyc + 1;
            chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 0);
            chk("err_status", {31'b0, err}, {31'b0, err_model});
            if (mem_write) begin
                chk("write_expected", {31'b0, wq.size() != 0}, 1);
                if (wq.size() != 0) begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_cycle", mon_c, w.cyc);
                    chk("write_addr", {18'b0, mem_waddr}, {18'b0, w.waddr});
                    chk("read_addr_hold", {18'b0, mem_raddr}, {18'b0, w.raddr});
                    chk("write_data", {22'b0, mem_wdata}, {22'b0, w.wdata});
                end
            end
            if (done) begin
                chk("done_expected", {31'b0, dq.size() != 0}, 1);
                chk("busy_at_done", {31'b0, busy}, 0);
                if (dq.size() != 0) begin
                    dn_t dn;
                    dn = dq.pop_front();
                    chk("done_cycle", mon_c, dn.cyc);
                    chk("done_err", {31'b0, err}, {31'b0, dn.err});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and model it at word level. ab_e>0 raises abort so
    // it is sampled ab_e edges after acceptance. Returns at the start of
    // the completion cycle so a following command lands back-to-back.
    task automatic do_cmd(input int s, input int d, input int l, input int ab_e, input bit spur);
        int t, words, last;
        bit aborted;
        wr_t w;
        dn_t dn;
        start = 1'b1;
        src = 14'(s);
        dst = 14'(d);
        len = 14'(l);
        step();
        t = cyc;
        start = 1'b0;
        if (l == 0) begin
            dn.cyc = t + 1; dn.err = 1'b0; dq.push_back(dn);
            err_model = 1'b0;
        end else if (d >= 'h2000 || d + l - 1 > 'h1FFF || s + l - 1 > 'h3FFF) begin
            dn.cyc = t + 1; dn.err = 1'b1; dq.push_back(dn);
            err_model = 1'b1;
        end else begin
            aborted = (ab_e > 0) && (ab_e <= 2 * l);
            words = aborted ? ab_e / 2 : l;
            for (int k = 0; k < words; k++) begin
                w.wdata = (s + k >= 'h2000) ? rom_f(s + k) : ref_mem[s + k];
                ref_mem[d + k] = w.wdata;
                w.cyc = t + 2 + 2 * k;
                w.waddr = 14'(d + k);
                w.raddr = 14'(s + k);
                wq.push_back(w);
            end
            last = aborted ? ab_e : 2 * l;
            dn.cyc = t + last + 1; dn.err = aborted; dq.push_back(dn);
            err_model = 1'b0;
            chk("busy_after_start", {31'b0, busy}, 1);
            for (int i = 1; i <= last; i++) begin
                if (i == 1 && spur) begin
                    start = 1'b1;
                    src = 14'($urandom);
                    dst = 14'($urandom_range(0, 'h1000));
                    len = 14'($urandom_range(1, 4));
                end
                if (aborted && i == ab_e) abort = 1'b1;
                step();
                start = 1'b0;
                abort = 1'b0;
                if (aborted && i == ab_e) err_model = 1'b1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rs, rd, rl, sel, bad;
        for (int i = 0; i < 8192; i++) ref_mem[i] = ram_init(i);
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_done", {31'b0, done}, 0);
        chk("reset_err", {31'b0, err}, 0);
        chk("reset_mem_read", {31'b0, mem_read}, 0);
        chk("reset_mem_write", {31'b0, mem_write}, 0);
        chk("reset_raddr", {18'b0, mem_raddr}, 0);
        chk("reset_waddr", {18'b0, mem_waddr}, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        step();

        // Directed cases, issued back-to-back.
        do_cmd('h0100, 'h0200, 4, 0, 1'b0);
        do_cmd('h2000, 'h0000, 3, 0, 1'b1);
        do_cmd('h0000, 'h1FFF, 2, 0, 1'b0);
        do_cmd('h0000, 'h2000, 1, 0, 1'b0);
        do_cmd('h0005, 'h0005, 0, 0, 1'b0);
        do_cmd('h2100, 'h0400, 8, 6, 1'b0);
        do_cmd('h3FFF, 'h0010, 2, 0, 1'b0);
        do_cmd('h0300, 'h0302, 6, 0, 1'b1);

        // Reset in the middle of a copy: two words land, nothing after.
        begin
            wr_t w;
            int t;
            start = 1'b1; src = 14'h2010; dst = 14'h0800; len = 14'd6;
            step();
            t = cyc;
            start = 1'b0;
            err_model = 1'b0;
            for (int k = 0; k < 2; k++) begin
                w.wdata = rom_f('h2010 + k);
                ref_mem['h800 + k] = w.wdata;
                w.cyc = t + 2 + 2 * k;
                w.waddr = 14'('h800 + k);
                w.raddr = 14'('h2010 + k);
                wq.push_back(w);
            end
            repeat (4) step();
            rst_n = 1'b0;
            err_model = 1'b0;
            #1;
            chk("midreset_busy", {31'b0, busy}, 0);
            chk("midreset_done", {31'b0, done}, 0);
            chk("midreset_err", {31'b0, err}, 0);
            chk("midreset_mem_read", {31'b0, mem_read}, 0);
            chk("midreset_mem_write", {31'b0, mem_write}, 0);
            repeat (3) step();
            rst_n = 1'b1;
            repeat (4) step();
        end
        do_cmd('h0100, 'h0900, 4, 0, 1'b0);

        // Randomized commands with random gaps (often none).
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 9);
            rl = $urandom_range(1, 12);
            rd = $urandom_range(0, 'h2000 - rl);
            rs = $urandom_range(0, 'h4000 - rl);
            if ($urandom_range(0, 2) == 0) begin
                rd = $urandom_range('h300, 'h310);
                rs = rd + $urandom_range(0, 6) - 3;
            end
            if (sel == 6) begin
                rd = $urandom_range('h2000, 'h3FFF);
            end else if (sel == 7) begin
                rl = $urandom_range(2, 300);
                rd = 'h2000 - rl + $urandom_range(1, rl - 1);
                rs = $urandom_range(0, 'h100);
            end else if (sel == 8) begin
                rl = $urandom_range(2, 300);
                rs = 'h4000 - rl + $urandom_range(1, rl - 1);
                rd = $urandom_range(0, 'h100);
            end else if (sel == 9) begin
                rl = 0;
            end
            do_cmd(rs, rd, rl, (sel == 5) ? $urandom_range(1, 2 * rl) : 0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (4) step();
        chk("writes_outstanding", wq.size(), 0);
        chk("dones_outstanding", dq.size(), 0);
        bad = 0;
        for (int i = 0; i < 8192; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("ram_image", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
